// File: rtl/wf_pkg.sv
// Shared definitions for the waterfall history memory: geometry defaults
// and the line-writer state encoding. Used by the scheduler, the screen
// generator and the BRAM wrapper.
package wf_pkg;

  localparam int WATERFALLSIZE_DEF = 256;
  localparam int LINEWIDTH_DEF     = 1024;
  localparam int LW_BITS_DEF       = $clog2(WATERFALLSIZE_DEF);
  localparam int XW_BITS_DEF       = $clog2(LINEWIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_PENDING = 2'd2
  } wf_state_t;

endpackage

// File: rtl/wf_row_tracker.sv
// Display row counter for the waterfall scan-out. Row 0 is the newest line;
// the memory line for a display row is (head - row) modulo the history depth,
// which wraps for free because the depth is a power of two.
module wf_row_tracker
  import wf_pkg::*;
#(
  parameter int LW_BITS = LW_BITS_DEF
) (
  input  logic               i_pixClk,
  input  logic               i_rst_n,
  input  logic               i_wfActive,
  input  logic               i_wf_sync,
  input  logic               i_lineEnd,
  input  logic [LW_BITS-1:0] i_head,
  output logic [LW_BITS-1:0] o_disp_line
);

  logic [LW_BITS-1:0] r_row;

  // Row clears on the pre-waterfall sync line, advances at each displayed line end.
  always_ff @(posedge i_pixClk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
    end else if (i_wf_sync) begin
      r_row <= '0;
    end else if (i_lineEnd && i_wfActive) begin
      r_row <= r_row + 1'b1;
    end
  end

  assign o_disp_line = i_head - r_row;

endmodule

// File: rtl/wf_line_scheduler.sv
// Waterfall line scheduler: arbitrates the single BRAM port between the
// display reader (priority while i_wfActive) and the spectrum line writer,
// and keeps the circular head pointer. A finished line is only made visible
// at the frame boundary so a displayed frame never tears.
// Optional feature macro: WF_DECIM_EN (write only 1 of every DECIMATION lines).
module wf_line_scheduler
  import wf_pkg::*;
#(
  parameter int WATERFALLSIZE = WATERFALLSIZE_DEF,
  parameter int LINEWIDTH     = LINEWIDTH_DEF,
  parameter int LW_BITS       = LW_BITS_DEF,
  parameter int XW_BITS       = XW_BITS_DEF,
  parameter int DECIMATION    = 4
) (
  input  logic                       i_pixClk,
  input  logic                       i_rst_n,
  input  logic                       i_wfActive,
  input  logic                       i_wf_sync,
  input  logic                       i_lineEnd,
  input  logic [XW_BITS-1:0]         i_addr_x,
  input  logic                       i_wr_valid,
  input  logic [7:0]                 i_wr_data,
  output logic                       o_wr_ready,
  output logic                       o_mem_en,
  output logic                       o_mem_we,
  output logic [LW_BITS+XW_BITS-1:0] o_mem_addr,
  output logic [7:0]                 o_mem_wdata,
  output logic [LW_BITS-1:0]         o_head,
  output logic                       o_line_pending
);

  localparam logic [LW_BITS-1:0] LINE_MAX = LW_BITS'(WATERFALLSIZE - 1);
  localparam logic [XW_BITS-1:0] COL_MAX  = XW_BITS'(LINEWIDTH - 1);

  wf_state_t          r_state;
  wf_state_t          w_next_state;
  logic [LW_BITS-1:0] r_head;
  logic [LW_BITS-1:0] r_wr_line;
  logic [XW_BITS-1:0] r_col;
  logic               r_sync_d;
  logic [LW_BITS-1:0] w_disp_line;
  logic               w_wr_ready;
  logic               w_line_pending;
  logic               w_sync_rise;
  logic               w_accept;
  logic               w_col_last;
  logic               w_line_done;
  logic               w_skip_line;
  logic               w_wr_mem;

  assign w_sync_rise = i_wf_sync & ~r_sync_d;
  assign w_accept    = w_wr_ready & i_wr_valid;
  assign w_col_last  = (r_col == COL_MAX);
  assign w_line_done = w_accept & w_col_last;
  assign w_wr_mem    = w_accept & ~w_skip_line;

  wf_row_tracker #(
    .LW_BITS (LW_BITS)
  ) u_row_tracker (
    .i_pixClk    (i_pixClk),
    .i_rst_n     (i_rst_n),
    .i_wfActive  (i_wfActive),
    .i_wf_sync   (i_wf_sync),
    .i_lineEnd   (i_lineEnd),
    .i_head      (r_head),
    .o_disp_line (w_disp_line)
  );

`ifdef WF_DECIM_EN
  localparam int DCNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  logic [DCNT_W-1:0] r_dcnt;

  // Count completed input lines; only the line at count 0 reaches memory.
  always_ff @(posedge i_pixClk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dcnt <= '0;
    end else if (w_line_done) begin
      r_dcnt <= (r_dcnt == DCNT_W'(DECIMATION - 1)) ? '0 : r_dcnt + 1'b1;
    end
  end

  assign w_skip_line = (r_dcnt != '0);
`else
  // Every line is written; DECIMATION has no effect in this build.
  assign w_skip_line = 1'b0 & (DECIMATION > 0);
`endif

  // Writer FSM state register.
  always_ff @(posedge i_pixClk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Writer FSM next state; skipped (decimated) lines never wait for a swap.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    w_next_state = ST_WRITE;
      ST_WRITE:   if (w_line_done && !w_skip_line) w_next_state = ST_PENDING;
      ST_PENDING: if (w_sync_rise) w_next_state = ST_WRITE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Writer FSM outputs; ready drops combinationally as soon as the display takes the port.
  always_comb begin
    w_wr_ready     = 1'b0;
    w_line_pending = 1'b0;
    case (r_state)
      ST_WRITE:   w_wr_ready     = ~i_wfActive;
      ST_PENDING: w_line_pending = 1'b1;
      default:    ;
    endcase
  end

  // Column counter, and head/write-line swap at the frame boundary.
  always_ff @(posedge i_pixClk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head    <= '0;
      r_wr_line <= LW_BITS'(1);
      r_col     <= '0;
      r_sync_d  <= 1'b0;
    end else begin
      r_sync_d <= i_wf_sync;
      if (w_accept) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
      end
      if ((r_state == ST_PENDING) && w_sync_rise) begin
        r_head    <= r_wr_line;
        r_wr_line <= (r_wr_line == LINE_MAX) ? '0 : r_wr_line + 1'b1;
      end
    end
  end

  // Registered memory port: display read wins; a write can only occur when inactive.
  always_ff @(posedge i_pixClk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else if (i_wfActive) begin
      o_mem_en   <= 1'b1;
      o_mem_we   <= 1'b0;
      o_mem_addr <= {w_disp_line, i_addr_x};
    end else if (w_wr_mem) begin
      o_mem_en    <= 1'b1;
      o_mem_we    <= 1'b1;
      o_mem_addr  <= {r_wr_line, r_col};
      o_mem_wdata <= i_wr_data;
    end else begin
      o_mem_en <= 1'b0;
      o_mem_we <= 1'b0;
    end
  end

  assign o_wr_ready     = w_wr_ready;
  assign o_line_pending = w_line_pending;
  assign o_head         = r_head;

endmodule

// File: tb/tb_wf_line_scheduler.sv
// Directed, scoreboarded bench for wf_line_scheduler on a reduced geometry
// (16 lines x 32 pixels) so the wrap-around cases stay short.
module tb_wf_line_scheduler;

  localparam int WS   = 16;
  localparam int LWID = 32;
  localparam int LWB  = 4;
  localparam int XWB  = 5;
  localparam int AW   = LWB + XWB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wfActive = 1'b0;
  logic           wf_sync = 1'b0;
  logic           lineEnd = 1'b0;
  logic [XWB-1:0] addr_x = '0;
  logic           wr_valid = 1'b0;
  logic [7:0]     wr_data = '0;
  logic           o_wr_ready;
  logic           o_mem_en;
  logic           o_mem_we;
  logic [AW-1:0]  o_mem_addr;
  logic [7:0]     o_mem_wdata;
  logic [LWB-1:0] o_head;
  logic           o_line_pending;

  int checks = 0;
  int errors = 0;

  logic [AW+7:0]  sb_q[$];
  logic [AW+7:0]  sb_e;
  logic [LWB-1:0] exp_line;
  int             exp_col;

  wf_line_scheduler #(
    .WATERFALLSIZE (WS),
    .LINEWIDTH     (LWID),
    .LW_BITS       (LWB),
    .XW_BITS       (XWB),
    .DECIMATION    (4)
  ) dut (
    .i_pixClk       (clk),
    .i_rst_n        (rst_n),
    .i_wfActive     (wfActive),
    .i_wf_sync      (wf_sync),
    .i_lineEnd      (lineEnd),
    .i_addr_x       (addr_x),
    .i_wr_valid     (wr_valid),
    .i_wr_data      (wr_data),
    .o_wr_ready     (o_wr_ready),
    .o_mem_en       (o_mem_en),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_head         (o_head),
    .o_line_pending (o_line_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (o_mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed addr=%0h data=%0h, expected no write", o_mem_addr, o_mem_wdata);
      end else begin
        sb_e = sb_q.pop_front();
        check("wr_addr", 32'(o_mem_addr), 32'(sb_e[AW+7:8]));
        check("wr_data", 32'(o_mem_wdata), 32'(sb_e[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_sample(input bit push);
    logic [7:0] d;
    d = 8'(exp_col * 7 + int'(exp_line) * 13);
    wr_valid = 1'b1;
    wr_data  = d;
    if (push) sb_q.push_back({exp_line, XWB'(exp_col), d});
    exp_col = (exp_col + 1) % LWID;
    tick();
  endtask

  task automatic send(input int n, input bit push);
    for (int i = 0; i < n; i++) wr_sample(push);
  endtask

  task automatic sync_pulse(input string tag, input int exp_head);
    wf_sync = 1'b1;
    tick();
    check(tag, 32'(o_head), 32'(exp_head));
    wf_sync = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 32'(o_mem_en), 0);
    check("rst_we", 32'(o_mem_we), 0);
    check("rst_addr", 32'(o_mem_addr), 0);
    check("rst_wdata", 32'(o_mem_wdata), 0);
    check("rst_head", 32'(o_head), 0);
    check("rst_pending", 32'(o_line_pending), 0);
    check("rst_ready", 32'(o_wr_ready), 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(o_wr_ready), 1);

`ifdef WF_DECIM_EN
    begin
      int wl;
      int hd;
      wl = 1;
      hd = 0;
      for (int k = 0; k < 8; k++) begin
        bit wr;
        wr = ((k % 4) == 0);
        exp_line = LWB'(wl);
        exp_col  = 0;
        send(LWID, wr);
        wr_valid = 1'b0;
        check("decim_pending", 32'(o_line_pending), 32'(wr));
        check("decim_ready", 32'(o_wr_ready), 32'(!wr));
        if (wr) begin
          hd = wl;
          wl = wl + 1;
        end
        sync_pulse("decim_head", hd);
      end
      check("decim_head_end", 32'(o_head), 2);
    end
`else
    // First line goes to line 1, then waits for the frame swap.
    exp_line = LWB'(1);
    exp_col  = 0;
    send(LWID, 1'b1);
    wr_valid = 1'b0;
    check("pend_flag", 32'(o_line_pending), 1);
    check("pend_ready", 32'(o_wr_ready), 0);
    wr_valid = 1'b1;
    repeat (3) tick();
    wr_valid = 1'b0;
    check("pend_head", 32'(o_head), 0);
    wf_sync = 1'b1;
    tick();
    check("swap1_head", 32'(o_head), 1);
    check("swap1_pending", 32'(o_line_pending), 0);
    wf_sync = 1'b0;
    tick();

    // Display reads: row 0 -> line 1, row 1 -> line 0.
    wfActive = 1'b1;
    addr_x   = XWB'(5);
    tick();
    check("disp_row0_addr", 32'(o_mem_addr), (1 << XWB) | 5);
    check("disp_en", 32'(o_mem_en), 1);
    check("disp_we", 32'(o_mem_we), 0);
    lineEnd = 1'b1;
    tick();
    lineEnd = 1'b0;
    tick();
    check("disp_row1_addr", 32'(o_mem_addr), 5);
    check("disp_ready", 32'(o_wr_ready), 0);
    wfActive = 1'b0;
    tick();
    check("idle_en", 32'(o_mem_en), 0);

    // Line 2 with a display stall mid-line and a sync while incomplete.
    exp_line = LWB'(2);
    exp_col  = 0;
    send(10, 1'b1);
    wfActive = 1'b1;
    #1;
    check("stall_ready_same_cycle", 32'(o_wr_ready), 0);
    repeat (4) tick();
    check("stall_we", 32'(o_mem_we), 0);
    wfActive = 1'b0;
    send(10, 1'b1);
    wr_valid = 1'b0;
    sync_pulse("partial_sync_head", 1);
    check("partial_pending", 32'(o_line_pending), 0);
    send(LWID - 20, 1'b1);
    wr_valid = 1'b0;
    check("line2_pending", 32'(o_line_pending), 1);
    sync_pulse("swap2_head", 2);

    // Commit until the write line wraps and head returns to 0.
    for (int l = 3; l <= WS; l++) begin
      exp_line = LWB'(l % WS);
      exp_col  = 0;
      send(LWID, 1'b1);
      wr_valid = 1'b0;
      sync_pulse("wrap_head", l % WS);
    end

    // Display row WS-1 reads line 1 (head 0); one more line end wraps row to 0.
    sync_pulse("row_clear_head", 0);
    wfActive = 1'b1;
    lineEnd  = 1'b1;
    repeat (WS - 1) tick();
    lineEnd = 1'b0;
    addr_x  = XWB'(9);
    tick();
    check("disp_last_row_addr", 32'(o_mem_addr), (1 << XWB) | 9);
    lineEnd = 1'b1;
    tick();
    lineEnd = 1'b0;
    tick();
    check("disp_row_wrap_addr", 32'(o_mem_addr), 9);
    wfActive = 1'b0;
    tick();

    // Asynchronous reset in the middle of a line.
    exp_line = LWB'(1);
    exp_col  = 0;
    send(20, 1'b1);
    wr_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(o_mem_we), 0);
    check("arst_en", 32'(o_mem_en), 0);
    check("arst_addr", 32'(o_mem_addr), 0);
    check("arst_head", 32'(o_head), 0);
    check("arst_ready", 32'(o_wr_ready), 0);
    check("arst_pending", 32'(o_line_pending), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rerst_ready", 32'(o_wr_ready), 1);
    exp_line = LWB'(1);
    exp_col  = 0;
    send(4, 1'b1);
    wr_valid = 1'b0;
    tick();
    tick();
    check("rerst_head", 32'(o_head), 0);
`endif

    tick();
    tick();
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
